uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

uart_tx_arbiter shares one UART transmitter between NUM_REQUESTERS byte-stream sources, granting the link to one requester for a whole packet at a time. It sits between packet producers (command responder, telemetry, debug) and the transmitter's byte input. Arbitration is round-robin at packet boundaries, with an optional idle gap between packets and a stall timeout that reclaims the link from a requester that stops mid-packet.

## Interface
Parameters:
- NUM_REQUESTERS, default 4: number of sources; must be 2..16.
- GAP_CYCLES, default 16: idle clk cycles inserted after each packet; 0 means no gap.
- STALL_TIMEOUT, default 1023: clk cycles a granted requester may hold req_valid low mid-packet before being aborted; 0 disables the timeout.
- ID_WIDTH, derived, max(1, $clog2(NUM_REQUESTERS)).

Ports:
- clk, input, 1: system clock. Single clock domain.
- rst, input, 1: reset, synchronous and active-high.
- req_data, input, 8*NUM_REQUESTERS: byte from requester i on bits [8i+7:8i].
- req_valid, input, NUM_REQUESTERS: requester i presents a byte.
- req_last, input, NUM_REQUESTERS: the byte from requester i is the final byte of its packet.
- req_ready, output, NUM_REQUESTERS: the byte from requester i is accepted when req_valid[i] and req_ready[i] are both high.
- tx_data, output, 8: byte to the transmitter.
- tx_valid, output, 1: tx_data is valid.
- tx_ready, input, 1: the transmitter accepts tx_data this cycle.
- grant_valid, output, 1: a requester currently owns the link.
- grant_id, output, ID_WIDTH: index of the owning requester.
- stall_abort, output, 1: 1-cycle pulse when a packet is aborted by timeout.

## Operation
- There are three states: IDLE, SEND and GAP. Reset places the block in IDLE.
- Round-robin pointer last_grant:
  - Reset value is NUM_REQUESTERS-1, so requester 0 wins first.
  - Priority order is last_grant+1, last_grant+2, and so on, wrapping modulo NUM_REQUESTERS.
- **IDLE**
  - If any req_valid bit is high, the first valid requester in priority order wins.
  - On the next edge: grant_id is set to the winner, grant_valid is set to 1, state moves to SEND, and the stall counter clears.
  - No requester is granted while req_valid is low.
- **SEND**
  - Combinational pass-through: tx_data = req_data[grant_id], tx_valid = req_valid[grant_id], req_ready[grant_id] = tx_ready.
  - All other req_ready bits are 0.
- **Transfer** (req_valid[grant_id] and tx_ready both high):
  - Clears the stall counter.
  - If req_last[grant_id] is also high, the packet ends at the next edge:
    - last_grant is set to grant_id and grant_valid falls.
    - State moves to GAP if GAP_CYCLES>0, otherwise to IDLE.
- **Stall**
  - In SEND, each cycle with req_valid[grant_id] low increments the stall counter.
  - When the counter reaches STALL_TIMEOUT (if nonzero), on the next edge: stall_abort pulses, last_grant is set to grant_id, grant_valid falls, and state moves to GAP or IDLE as above.
  - Cycles where tx_valid is high but tx_ready is low do not count as stalls.
  - The counter saturates and never wraps.
- **GAP**
  - The gap counter loads GAP_CYCLES-1 on entry and decrements each cycle.
  - On the edge where it reaches 0, state moves to IDLE.
  - During GAP, all req_ready bits are 0, tx_valid is 0 and grant_valid is 0.
- Outside SEND, tx_valid is 0, tx_data is 0 and req_ready is all zeros.
- req_last is sampled only on a transfer. A single-byte packet (valid and last together) is legal.
- A simultaneous transfer and timeout cannot occur, because a transfer clears the counter.
- The granting decision considers req_valid only; req_last in IDLE is ignored.
- Reset mid-operation discards any packet in progress; the block does not complete it.

## Timing
- Reset values:
  - Outputs: tx_valid=0, tx_data=0, req_ready=0, grant_valid=0, grant_id=0, stall_abort=0.
  - Internal: state=IDLE, last_grant=NUM_REQUESTERS-1, all counters=0.
- Grant latency: req_valid rising in cycle t while IDLE gives grant_valid and tx_valid high in cycle t+1.
- Data path: zero latency from req_* to tx_* in SEND. No byte is buffered inside the block.
- Gap: the last transfer occurs in cycle t. IDLE is entered at t+1+GAP_CYCLES, and the earliest next tx_valid is at t+2+GAP_CYCLES.
- Timeout: stall_abort is high exactly one cycle, in the cycle after the counter reaches STALL_TIMEOUT.
- grant_id holds its last value while grant_valid=0.

## Test plan
- **Reset values:** assert rst for 3 cycles with all req_valid high -> every output is 0; after release, grant_id=0 and grant_valid=1 one cycle later.
- **Round-robin:** all 4 requesters send 2-byte packets (0xA0,0xA1; 0xB0,0xB1; …) with tx_ready=1 and GAP_CYCLES=16 -> tx order 0,1,2,3,0. Exactly 16 idle cycles separate the end of one packet from the next grant cycle.
- **Backpressure:** tx_ready low for 2000 cycles while the granted requester holds valid -> no stall_abort, data is held stable, and the byte transfers when tx_ready rises.
- **Stall abort:** requester 2 sends 1 byte without last, then drops valid, with STALL_TIMEOUT=1023 -> a stall_abort pulse after 1023 stall cycles, then grant passes to requester 3.
- **Single-byte packet:** valid and last together on requester 1 only, GAP_CYCLES=0 -> one transfer, grant_valid low the next cycle, and the next request granted one cycle after that.
- **Mid-packet reset:** rst during byte 2 of a 5-byte packet -> outputs zero next cycle, and the new arbitration starts from requester 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter byte input between
// NUM_REQUESTERS packet sources. The link is owned by one requester for a
// whole packet. Ownership moves round-robin at packet boundaries. An optional
// idle gap follows each packet. A stall timeout reclaims the link from an
// owner that stops presenting bytes mid-packet.
//
// Ports:
//   clk, rst        - clock; synchronous active-high reset
//   req_data/valid/last/ready - per-requester byte streams (byte i on [8i+7:8i])
//   tx_data/valid/ready       - byte stream to the transmitter
//   grant_valid, grant_id     - current link owner
//   stall_abort               - 1-cycle pulse when a packet is dropped by timeout
module uart_tx_arbiter #(
  parameter  int NUM_REQUESTERS = 4,
  parameter  int GAP_CYCLES     = 16,
  parameter  int STALL_TIMEOUT  = 1023,
  localparam int ID_WIDTH       = (NUM_REQUESTERS > 2) ? $clog2(NUM_REQUESTERS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [8*NUM_REQUESTERS-1:0] req_data,
  input  logic [NUM_REQUESTERS-1:0]   req_valid,
  input  logic [NUM_REQUESTERS-1:0]   req_last,
  output logic [NUM_REQUESTERS-1:0]   req_ready,
  output logic [7:0]                  tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic                        grant_valid,
  output logic [ID_WIDTH-1:0]         grant_id,
  output logic                        stall_abort
);
  localparam int SW = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [SW-1:0] STALL_LIM = SW'(STALL_TIMEOUT);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t              state, state_n;
  logic [ID_WIDTH-1:0] last_grant, last_grant_n, grant_id_n;
  logic [SW-1:0]       stall_cnt, stall_cnt_n;
  logic [GW-1:0]       gap_cnt, gap_cnt_n;
  logic                abort_n;

  // Per-requester byte lanes, so the mux can index by grant_id directly.
  logic [7:0] lane [NUM_REQUESTERS];
  for (genvar g = 0; g < NUM_REQUESTERS; g++) begin : g_lane
    assign lane[g] = req_data[8*g +: 8];
  end

  // Round-robin pick: first valid requester after last_grant, wrapping.
  logic                any_valid;
  logic [ID_WIDTH-1:0] winner, idx;
  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    idx       = '0;
    for (int i = 1; i <= NUM_REQUESTERS; i++) begin
      idx = ID_WIDTH'((int'(last_grant) + i) % NUM_REQUESTERS);
      if (!any_valid && req_valid[idx]) begin
        any_valid = 1'b1;
        winner    = idx;
      end
    end
  end

  logic xfer, timeout_hit;
  assign xfer        = (state == SEND) && req_valid[grant_id] && tx_ready;
  // Transfer takes priority; it clears the counter in the same cycle.
  assign timeout_hit = (STALL_TIMEOUT != 0) && (state == SEND) &&
                       (stall_cnt == STALL_LIM) && !xfer;

  // Pass-through datapath: nothing is buffered, owner drives tx directly.
  always_comb begin
    req_ready = '0;
    tx_data   = 8'h00;
    tx_valid  = 1'b0;
    if (state == SEND) begin
      req_ready[grant_id] = tx_ready;
      tx_data             = lane[grant_id];
      tx_valid            = req_valid[grant_id];
    end
  end

  assign grant_valid = (state == SEND);

  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    grant_id_n   = grant_id;
    stall_cnt_n  = stall_cnt;
    gap_cnt_n    = gap_cnt;
    abort_n      = 1'b0;
    unique case (state)
      IDLE: begin
        if (any_valid) begin
          state_n     = SEND;
          grant_id_n  = winner;
          stall_cnt_n = '0;
        end
      end
      SEND: begin
        if (xfer) stall_cnt_n = '0;
        else if (!req_valid[grant_id] && stall_cnt != '1) stall_cnt_n = stall_cnt + 1'b1;
        if ((xfer && req_last[grant_id]) || timeout_hit) begin
          abort_n      = timeout_hit;
          last_grant_n = grant_id;
          if (GAP_CYCLES > 0) begin
            state_n   = GAP;
            gap_cnt_n = GW'(GAP_CYCLES - 1);
          end else begin
            state_n = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_n = IDLE;
        else gap_cnt_n = gap_cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= ID_WIDTH'(NUM_REQUESTERS - 1);
      grant_id    <= '0;
      stall_cnt   <= '0;
      gap_cnt     <= '0;
      stall_abort <= 1'b0;
    end else begin
      state       <= state_n;
      last_grant  <= last_grant_n;
      grant_id    <= grant_id_n;
      stall_cnt   <= stall_cnt_n;
      gap_cnt     <= gap_cnt_n;
      stall_abort <= abort_n;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter. Main instance uses default parameters and is
// checked through an expected-event scoreboard; a second instance with
// GAP_CYCLES=0 and the timeout disabled covers back-to-back packets.
module tb_uart_tx_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] req_data;
  logic [3:0]  req_valid, req_last, req_ready;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, grant_valid, stall_abort;
  logic [1:0]  grant_id;

  logic [31:0] a_data;
  logic [3:0]  a_valid, a_last, a_rdy;
  logic [7:0]  a_txd;
  logic        a_txv, a_txr, a_gv, a_ab;
  logic [1:0]  a_gid;

  always #5 clk = ~clk;

  uart_tx_arbiter dut (
    .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid),
    .req_last(req_last), .req_ready(req_ready), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .grant_valid(grant_valid),
    .grant_id(grant_id), .stall_abort(stall_abort));

  uart_tx_arbiter #(.GAP_CYCLES(0), .STALL_TIMEOUT(0)) dut0 (
    .clk(clk), .rst(rst), .req_data(a_data), .req_valid(a_valid),
    .req_last(a_last), .req_ready(a_rdy), .tx_data(a_txd),
    .tx_valid(a_txv), .tx_ready(a_txr), .grant_valid(a_gv),
    .grant_id(a_gid), .stall_abort(a_ab));

  typedef struct {bit abort; int id; logic [7:0] data;} exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  bit gap_chk = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic push(input bit ab, input int id, input logic [7:0] d);
    exp_t e;
    e.abort = ab; e.id = id; e.data = d;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: every accepted byte and every abort pulse must match
  // the next expected event. Also measures the gap between packets.
  initial begin
    exp_t e;
    int   cyc = 0, t_last = 0;
    bit   have_last = 1'b0, prev_v = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst !== 1'b1) begin
        if ((tx_valid && tx_ready) || stall_abort) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected act=abort%0b/id%0d/%0h exp=none",
                     stall_abort, grant_id, tx_data);
          end else begin
            e = exp_q.pop_front();
            if (e.abort != stall_abort || e.id != int'(grant_id) ||
                (!e.abort && e.data !== tx_data)) begin
              errors++;
              $display("FAIL sb_event act=abort%0b/id%0d/%0h exp=abort%0b/id%0d/%0h",
                       stall_abort, grant_id, tx_data, e.abort, e.id, e.data);
            end
          end
        end
        if (gap_chk && tx_valid && !prev_v && have_last) begin
          chk("gap_len", cyc - t_last, 32'd18);
          have_last = 1'b0;
        end
        if (gap_chk && tx_valid && tx_ready && req_last[grant_id]) begin
          t_last = cyc; have_last = 1'b1;
        end
      end
      prev_v = tx_valid;
    end
  end

  // Drives one packet on requester id with tx_ready assumed high.
  task automatic send_pkt(input int id, input int n, input logic [7:0] base, input bit with_last);
    int guard;
    for (int b = 0; b < n; b++) begin
      req_data[id*8 +: 8] = base + 8'(b);
      req_valid[id] = 1'b1;
      req_last[id]  = with_last && (b == n - 1);
      guard = 0;
      do begin @(negedge clk); guard++; end while (!req_ready[id] && guard < 5000);
      if (guard >= 5000) chk("send_timeout", 32'(id), 32'hFFFF);
      @(posedge clk); #1;
    end
    req_valid[id] = 1'b0;
    req_last[id]  = 1'b0;
    req_data[id*8 +: 8] = 8'h00;
  endtask

  initial begin
    int  k;
    bit  bad;
    rst = 1'b1; tx_ready = 1'b0;
    req_data = 32'h44332211; req_valid = 4'hF; req_last = 4'h0;
    a_data = '0; a_valid = '0; a_last = '0; a_txr = 1'b0;

    // Reset with all requesters valid: outputs stay zero.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_outs", {tx_valid, tx_data, req_ready, grant_valid, grant_id, stall_abort}, 0);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); chk("rst_idle", grant_valid, 0);
    @(negedge clk);
    chk("first_gv", grant_valid, 1);
    chk("first_gid", grant_id, 0);
    @(posedge clk); #1 rst = 1'b1; req_valid = '0; req_data = '0;
    @(posedge clk); #1 rst = 1'b0;

    // GAP_CYCLES=0 instance: back-to-back single-byte packet and no timeout.
    a_txr = 1'b1; a_valid[1] = 1'b1; a_data[15:8] = 8'h5A; a_last[1] = 1'b1;
    @(negedge clk); chk("g0_idle", a_gv, 0);
    @(posedge clk); #1 a_valid[0] = 1'b1; a_data[7:0] = 8'h0F;
    @(negedge clk);
    chk("g0_gid1", {a_gv, a_gid, a_txv, a_txd}, {1'b1, 2'd1, 1'b1, 8'h5A});
    chk("g0_ready", a_rdy, 4'b0010);
    @(posedge clk); #1 a_valid[1] = 1'b0; a_last[1] = 1'b0;
    @(negedge clk); chk("g0_gv_low", a_gv, 0);
    @(negedge clk);
    chk("g0_gid0", {a_gv, a_gid, a_txd}, {1'b1, 2'd0, 8'h0F});
    @(posedge clk); #1 a_valid[0] = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a_ab || !a_gv) bad = 1'b1;
    end
    chk("g0_no_timeout", bad, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;

    // Round robin: all four requesters, 2-byte packets, expect 0,1,2,3,0.
    tx_ready = 1'b1;
    push(0, 0, 8'hA0); push(0, 0, 8'hA1);
    push(0, 1, 8'hB0); push(0, 1, 8'hB1);
    push(0, 2, 8'hC0); push(0, 2, 8'hC1);
    push(0, 3, 8'hD0); push(0, 3, 8'hD1);
    push(0, 0, 8'hA2); push(0, 0, 8'hA3);
    gap_chk = 1'b1;
    fork
      begin send_pkt(0, 2, 8'hA0, 1); send_pkt(0, 2, 8'hA2, 1); end
      send_pkt(1, 2, 8'hB0, 1);
      send_pkt(2, 2, 8'hC0, 1);
      send_pkt(3, 2, 8'hD0, 1);
    join
    gap_chk = 1'b0;

    // Backpressure: requester 1 holds a byte for 2000 cycles.
    tx_ready = 1'b0;
    push(0, 1, 8'h5C);
    req_valid[1] = 1'b1; req_data[15:8] = 8'h5C; req_last[1] = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!grant_valid && k < 100);
    chk("bp_grant", {grant_valid, grant_id}, {1'b1, 2'd1});
    bad = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (tx_data !== 8'h5C || !tx_valid || stall_abort || req_ready !== 4'h0) bad = 1'b1;
    end
    chk("bp_stable", bad, 0);
    @(posedge clk); #1 tx_ready = 1'b1;
    @(negedge clk); chk("bp_ready", req_ready, 4'b0010);
    @(posedge clk); #1 req_valid[1] = 1'b0; req_last[1] = 1'b0;

    // Stall abort: requester 2 sends one byte without last, then goes quiet.
    push(0, 2, 8'hD0); push(1, 2, 8'h00);
    send_pkt(2, 1, 8'hD0, 0);
    k = 0;
    do begin @(negedge clk); k++; end while (!stall_abort && k < 3000);
    chk("abort_lat", k, 1025);
    chk("abort_gv", grant_valid, 0);
    @(negedge clk); chk("abort_pulse", stall_abort, 0);
    @(posedge clk); #1;
    push(0, 3, 8'h33); push(0, 0, 8'h30);
    fork
      send_pkt(3, 1, 8'h33, 1);
      send_pkt(0, 1, 8'h30, 1);
    join

    // Mid-packet reset during byte 2 of a 5-byte packet from requester 3.
    push(0, 3, 8'hE0); push(0, 3, 8'hE1);
    req_valid[3] = 1'b1; req_data[31:24] = 8'hE0; req_last[3] = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!grant_valid && k < 100);
    chk("mr_grant", grant_id, 3);
    @(posedge clk); #1 req_data[31:24] = 8'hE1;
    @(posedge clk); #1 req_data[31:24] = 8'hE2; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    req_valid = 4'b1101; req_last = 4'b0001;
    req_data = {8'hE2, 8'hF2, 8'h00, 8'hF0};
    push(0, 0, 8'hF0);
    @(negedge clk);
    chk("mr_outs", {tx_valid, tx_data, req_ready, grant_valid, grant_id, stall_abort}, 0);
    @(negedge clk);
    chk("mr_regrant", {grant_valid, grant_id}, {1'b1, 2'd0});
    @(posedge clk); #1 req_valid = '0; req_last = '0; req_data = '0;
    repeat (20) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
